// File: rtl/charge_session_ctrl_pkg.sv
// charge_session_ctrl_pkg: mode codes, per-port state encoding and countdown steps.
package charge_session_ctrl_pkg;
  localparam logic [3:0] MODE_STANDARD = 4'b0001;
  localparam logic [3:0] MODE_FAST = 4'b0101;
  localparam int STEP_STANDARD = 1;
  localparam int STEP_FAST = 2;
  typedef enum logic [1:0] {IDLE, CHARGING, DONE} portState_t;
  function automatic logic isValidMode(input logic [3:0] mode);
    return mode == MODE_STANDARD || mode == MODE_FAST;
  endfunction
endpackage

// File: rtl/charge_port_fsm.sv
// charge_port_fsm: one port's IDLE/CHARGING/DONE session FSM with saturating countdown.
module charge_port_fsm
  import charge_session_ctrl_pkg::*;
#(
  parameter int TIME_W = 12
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Tick,
  input  logic [3:0]        Mode,
  input  logic [TIME_W-1:0] Duration,
  input  logic              Start,
  input  logic              Grant,
  input  logic              Stop,
  input  logic              Ack,
  output logic              ChargingNext,
  output logic              CounterEnable,
  output logic              Done,
  output logic              Reject,
  output logic [TIME_W-1:0] RemainingTime
);
  portState_t state;
  logic fast;
  logic expire;
  logic [TIME_W-1:0] step, decremented;
  assign step = fast ? TIME_W'(STEP_FAST) : TIME_W'(STEP_STANDARD);
  assign decremented = RemainingTime > step ? RemainingTime - step : '0;
  assign expire = Tick && decremented == '0;
  // Feeds the top's ActiveCount register so it tracks CounterEnable edge for edge.
  assign ChargingNext = state == CHARGING ? !Stop && !expire : state == IDLE && Start && Grant;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      fast <= 1'b0;
      CounterEnable <= 1'b0;
      Done <= 1'b0;
      Reject <= 1'b0;
      RemainingTime <= '0;
    end else begin
      Reject <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (Grant) begin
            state <= CHARGING;
            RemainingTime <= Duration;
            fast <= Mode == MODE_FAST;
            CounterEnable <= 1'b1;
          end else Reject <= 1'b1;
        end
        CHARGING: if (Stop) begin
          state <= IDLE;
          RemainingTime <= '0;
          CounterEnable <= 1'b0;
        end else if (Tick) begin
          RemainingTime <= decremented;
          if (expire) begin
            state <= DONE;
            CounterEnable <= 1'b0;
            Done <= 1'b1;
          end
        end
        DONE: if (Ack) begin
          state <= IDLE;
          Done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/charge_session_ctrl.sv
// charge_session_ctrl: multi-port charging sessions with lowest-index-first slot arbitration.
module charge_session_ctrl
  import charge_session_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TIME_W = 12,
  parameter int MAX_ACTIVE = 2
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic                          Tick,
  input  logic [4*NUM_PORTS-1:0]        Mode,
  input  logic [TIME_W*NUM_PORTS-1:0]   Duration,
  input  logic [NUM_PORTS-1:0]          Start,
  input  logic [NUM_PORTS-1:0]          Stop,
  input  logic [NUM_PORTS-1:0]          Ack,
  output logic [NUM_PORTS-1:0]          CounterEnable,
  output logic [NUM_PORTS-1:0]          Done,
  output logic [NUM_PORTS-1:0]          Reject,
  output logic [TIME_W*NUM_PORTS-1:0]   RemainingTime,
  output logic [$clog2(NUM_PORTS+1)-1:0] ActiveCount
);
  localparam int CNT_W = $clog2(NUM_PORTS + 1);
  logic [NUM_PORTS-1:0] grant, chargingNext;
  // ActiveCount still counts ports ending this cycle, so their slots free up one cycle later.
  always_comb begin
    int granted;
    granted = 0;
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (Start[i] && !CounterEnable[i] && !Done[i] && isValidMode(Mode[4*i+:4]) &&
          Duration[TIME_W*i+:TIME_W] != '0 && int'(ActiveCount) + granted < MAX_ACTIVE) begin
        grant[i] = 1'b1;
        granted++;
      end
    end
  end
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) ActiveCount <= '0;
    else ActiveCount <= CNT_W'($countones(chargingNext));
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : gPort
    charge_port_fsm #(.TIME_W(TIME_W)) uPort (
      .Clk(Clk),
      .nReset(nReset),
      .Tick(Tick),
      .Mode(Mode[4*g+:4]),
      .Duration(Duration[TIME_W*g+:TIME_W]),
      .Start(Start[g]),
      .Grant(grant[g]),
      .Stop(Stop[g]),
      .Ack(Ack[g]),
      .ChargingNext(chargingNext[g]),
      .CounterEnable(CounterEnable[g]),
      .Done(Done[g]),
      .Reject(Reject[g]),
      .RemainingTime(RemainingTime[TIME_W*g+:TIME_W])
    );
  end
endmodule

// File: tb/tb_charge_session_ctrl.sv
// tb_charge_session_ctrl: directed and random checks against a per-port session model.
module tb_charge_session_ctrl;
  logic Clk = 1'b0, nReset = 1'b1, Tick = 1'b0;
  logic [15:0] Mode = '0;
  logic [47:0] Duration = '0;
  logic [3:0] Start = '0, Stop = '0, Ack = '0;
  logic [3:0] CounterEnable, Done, Reject;
  logic [47:0] RemainingTime;
  logic [2:0] ActiveCount;
  int errors = 0, checks = 0;
  int mSt[4], mRem[4], mStep[4];
  logic [3:0] mRej;

  charge_session_ctrl #(.NUM_PORTS(4), .TIME_W(12), .MAX_ACTIVE(2)) dut (
    .Clk(Clk), .nReset(nReset), .Tick(Tick), .Mode(Mode), .Duration(Duration),
    .Start(Start), .Stop(Stop), .Ack(Ack), .CounterEnable(CounterEnable), .Done(Done),
    .Reject(Reject), .RemainingTime(RemainingTime), .ActiveCount(ActiveCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mSt[i] = 0; mRem[i] = 0; mStep[i] = 1;
    end
    mRej = '0;
  endtask

  // States: 0 idle, 1 charging, 2 done. Grants use the occupancy seen before this edge.
  task automatic modelEdge();
    int act = 0, granted = 0;
    for (int i = 0; i < 4; i++) if (mSt[i] == 1) act++;
    for (int i = 0; i < 4; i++) begin
      int md = int'(Mode[4*i+:4]);
      int d = int'(Duration[12*i+:12]);
      mRej[i] = 1'b0;
      if (mSt[i] == 0) begin
        if (Start[i]) begin
          if ((md == 1 || md == 5) && d != 0 && act + granted < 2) begin
            mSt[i] = 1; mRem[i] = d; mStep[i] = (md == 5) ? 2 : 1; granted++;
          end else mRej[i] = 1'b1;
        end
      end else if (mSt[i] == 1) begin
        if (Stop[i]) begin
          mSt[i] = 0; mRem[i] = 0;
        end else if (Tick) begin
          mRem[i] = (mRem[i] - mStep[i] < 0) ? 0 : mRem[i] - mStep[i];
          if (mRem[i] == 0) mSt[i] = 2;
        end
      end else if (Ack[i]) mSt[i] = 0;
    end
  endtask

  task automatic compareAll();
    logic [3:0] eCe = '0, eDone = '0;
    logic [47:0] eRt = '0;
    int ac = 0;
    for (int i = 0; i < 4; i++) begin
      eCe[i] = mSt[i] == 1;
      eDone[i] = mSt[i] == 2;
      eRt[12*i+:12] = 12'(mRem[i]);
      if (mSt[i] == 1) ac++;
    end
    chk("model_ce", 64'(CounterEnable), 64'(eCe));
    chk("model_done", 64'(Done), 64'(eDone));
    chk("model_reject", 64'(Reject), 64'(mRej));
    chk("model_rt", 64'(RemainingTime), 64'(eRt));
    chk("model_ac", 64'(ActiveCount), 64'(ac));
  endtask

  task automatic cycle();
    @(posedge Clk);
    modelEdge();
    #1;
    compareAll();
    Start = '0; Stop = '0; Ack = '0; Tick = 1'b0;
  endtask

  task automatic setPort(input int i, input logic [3:0] md, input logic [11:0] d);
    Mode[4*i+:4] = md;
    Duration[12*i+:12] = d;
  endtask

  initial begin
    logic [3:0] modes [4] = '{4'b0001, 4'b0101, 4'b0011, 4'b0000};
    modelReset();
    #2 nReset = 1'b0;
    #2;
    chk("rst_ce", 64'(CounterEnable), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_rt", 64'(RemainingTime), 64'(0));
    chk("rst_ac", 64'(ActiveCount), 64'(0));
    @(negedge Clk) nReset = 1'b1;
    cycle();
    // Standard session: 3 ticks to done, then acknowledged.
    setPort(0, 4'b0001, 12'd3); Start[0] = 1'b1; cycle();
    chk("std_ce_rise", 64'(CounterEnable[0]), 64'(1));
    chk("std_rt_load", 64'(RemainingTime[11:0]), 64'(3));
    for (int k = 0; k < 3; k++) begin Tick = 1'b1; cycle(); end
    chk("std_done", 64'(Done[0]), 64'(1));
    chk("std_rt_zero", 64'(RemainingTime[11:0]), 64'(0));
    chk("std_ce_fall", 64'(CounterEnable[0]), 64'(0));
    Ack[0] = 1'b1; cycle();
    chk("std_ack_idle", 64'(Done[0]), 64'(0));
    // Fast session saturates 5,3,1,0.
    setPort(1, 4'b0101, 12'd5); Start[1] = 1'b1; cycle();
    Tick = 1'b1; cycle();
    chk("fast_rt_3", 64'(RemainingTime[23:12]), 64'(3));
    Tick = 1'b1; cycle(); Tick = 1'b1; cycle();
    chk("fast_rt_0", 64'(RemainingTime[23:12]), 64'(0));
    chk("fast_done", 64'(Done[1]), 64'(1));
    Ack[1] = 1'b1; cycle();
    // Rejections: bad mode, zero duration.
    setPort(2, 4'b0011, 12'd7); Start[2] = 1'b1; cycle();
    chk("badmode_rej", 64'(Reject[2]), 64'(1));
    chk("badmode_ce", 64'(CounterEnable[2]), 64'(0));
    cycle();
    chk("rej_pulse_end", 64'(Reject[2]), 64'(0));
    setPort(2, 4'b0001, 12'd0); Start[2] = 1'b1; cycle();
    chk("zerodur_rej", 64'(Reject[2]), 64'(1));
    // Three simultaneous starts with two slots.
    setPort(0, 4'b0001, 12'd10); setPort(1, 4'b0101, 12'd10); setPort(2, 4'b0001, 12'd10);
    Start = 4'b0111; cycle();
    chk("arb_ce", 64'(CounterEnable), 64'(4'b0011));
    chk("arb_rej", 64'(Reject), 64'(4'b0100));
    chk("arb_ac", 64'(ActiveCount), 64'(2));
    Stop[0] = 1'b1; Start[2] = 1'b1; cycle();
    chk("freed_same_cycle_rej", 64'(Reject[2]), 64'(1));
    Start[2] = 1'b1; cycle();
    chk("freed_next_cycle_ce", 64'(CounterEnable[2]), 64'(1));
    chk("freed_next_cycle_ac", 64'(ActiveCount), 64'(2));
    Stop = 4'b0110; cycle();
    // Stop beats a same-cycle expiry.
    setPort(0, 4'b0001, 12'd1); Start[0] = 1'b1; cycle();
    Stop[0] = 1'b1; Tick = 1'b1; cycle();
    chk("stopwin_done", 64'(Done[0]), 64'(0));
    chk("stopwin_rt", 64'(RemainingTime[11:0]), 64'(0));
    cycle();
    chk("stopwin_done_later", 64'(Done[0]), 64'(0));
    // Asynchronous reset mid-session on two ports.
    setPort(0, 4'b0001, 12'd20); setPort(3, 4'b0001, 12'd20); Start = 4'b1001; cycle();
    chk("pre_rst_ac", 64'(ActiveCount), 64'(2));
    #2 nReset = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge Clk) nReset = 1'b1;
    cycle(); cycle();
    chk("post_rst_done", 64'(Done), 64'(0));
    chk("post_rst_rej", 64'(Reject), 64'(0));
    chk("post_rst_ce", 64'(CounterEnable), 64'(0));
    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        setPort(i, modes[$urandom_range(0, 3)], 12'($urandom_range(0, 9)));
        Start[i] = $urandom_range(0, 3) == 0;
        Stop[i] = $urandom_range(0, 15) == 0;
        Ack[i] = $urandom_range(0, 3) == 0;
      end
      Tick = $urandom_range(0, 1) == 1;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
